// File: rtl/iter_mul_check_if.sv
// -----------------------------------------------------------------------------
// iter_mul_check_if
//   Handshake/data bundle for the iterative shift-add reconstruction unit.
//   The master side feeds operand sets and consumes results. The slave side is
//   the iter_mul_check datapath.
//
//   Operand channel : in_valid, in_ready, quotient, divisor, remainder
//   Result channel  : out_valid, out_ready, product, rem_ok
//
//   WIDTH must match the WIDTH of the iter_mul_check instance it connects to.
// -----------------------------------------------------------------------------
interface iter_mul_check_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     remainder;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 rem_ok;

  modport master (
    output in_valid,
    output quotient,
    output divisor,
    output remainder,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  rem_ok
  );

  modport slave (
    input  in_valid,
    input  quotient,
    input  divisor,
    input  remainder,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output rem_ok
  );
endinterface

// File: rtl/iter_mul_check.sv
// -----------------------------------------------------------------------------
// iter_mul_check
//   Rebuilds a dividend as quotient*divisor + remainder, one multiplier bit per
//   cycle (inverse of the iterative restoring divider), and flags whether the
//   remainder is in range for the divisor (remainder < divisor).
//
//   Ports:
//     clk    : single rising-edge clock
//     reset  : asynchronous, active-high; returns the block to IDLE at once and
//              discards any in-flight or undelivered result
//     bus    : iter_mul_check_if.slave
//              in_valid/in_ready   operand handshake (quotient, divisor,
//                                  remainder sampled only on the accept edge)
//              out_valid/out_ready result handshake (product, rem_ok)
//
//   Flow: IDLE (accept) -> BUSY (WIDTH cycles) -> DONE (hold until taken).
//   With out_ready tied high, one operation completes every WIDTH+2 cycles.
//   WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module iter_mul_check #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  iter_mul_check_if.slave    bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q,  state_d;
  logic [2*WIDTH-1:0]    acc_q,    acc_d;
  logic [2*WIDTH-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  rem_ok_q, rem_ok_d;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    rem_ok_d = rem_ok_q;

    case (state_q)
      S_IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone marks an accept.
        if (bus.in_valid) begin
          acc_d    = {{WIDTH{1'b0}}, bus.remainder};
          mcand_d  = {{WIDTH{1'b0}}, bus.divisor};
          mplier_d = bus.quotient;
          count_d  = '0;
          rem_ok_d = (bus.remainder < bus.divisor);
          state_d  = S_BUSY;
        end
      end

      S_BUSY: begin
        // The 2W-bit accumulator cannot overflow: the largest result is
        // (2^W-1)^2 + (2^W-1) < 2^(2W).
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_ONE;
        if (count_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      rem_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      rem_ok_q <= rem_ok_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, no input-to-output path.
  // product follows acc and is only meaningful while out_valid is high.
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.product   = acc_q;
  assign bus.rem_ok    = rem_ok_q;

endmodule

// File: tb/tb_iter_mul_check.sv
module tb_iter_mul_check;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  iter_mul_check_if #(.WIDTH(W)) bus ();

  iter_mul_check #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a pending result becomes visible W cycles after the
  // accept edge and stays until taken. Checked at every falling edge.
  // ---------------------------------------------------------------------------
  bit          pend = 1'b0;
  longint      exp_p;
  bit          exp_ok;
  int          ready_cyc;
  bit          ev;

  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_product",   bus.product,   0);
    end else begin
      ev = pend && (cyc >= ready_cyc);
      check("in_ready",  bus.in_ready,  !pend);
      check("out_valid", bus.out_valid, ev);
      if (ev) begin
        check("product", bus.product, exp_p);
        check("rem_ok",  bus.rem_ok,  exp_ok);
      end
      if (!pend && bus.in_valid) begin
        pend      = 1'b1;
        ready_cyc = cyc + 1 + W;
        exp_p     = longint'(bus.quotient) * longint'(bus.divisor) + longint'(bus.remainder);
        exp_ok    = (bus.remainder < bus.divisor);
      end else if (ev && bus.out_ready) begin
        pend = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  int acc_e;

  task automatic send(input int q, input int d, input int r);
    int n;
    bus.quotient  = q[W-1:0];
    bus.divisor   = d[W-1:0];
    bus.remainder = r[W-1:0];
    bus.in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    acc_e        = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_prod, input bit exp_rok, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_valid"},   bus.out_valid, 1);
    check({name, "_product"}, bus.product,   exp_prod);
    check({name, "_rem_ok"},  bus.rem_ok,    exp_rok);
    if (exp_lat >= 0) check({name, "_latency"}, cyc - acc_e, exp_lat);
  endtask

  int prev_e;
  int rst_e;
  int q, d, r;
  int n;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.quotient  = '0;
    bus.divisor   = '0;
    bus.remainder = '0;

    @(negedge clk);
    check("reset_rem_ok",   bus.rem_ok,    0);
    check("reset_product",  bus.product,   0);
    check("reset_in_ready", bus.in_ready,  1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Nominal: 13*7+5 = 96, result exactly W cycles after accept.
    send(13, 7, 5);
    wait_result("nominal", 96, 1'b1, W);
    @(posedge clk); #1;

    // Maximum operands: 255*255+254 = 65279.
    send(255, 255, 254);
    wait_result("maximum", 65279, 1'b1, W);
    @(posedge clk); #1;

    // Degenerate operands.
    send(0, 9, 200);
    wait_result("q_zero", 200, 1'b0, W);
    @(posedge clk); #1;
    send(5, 0, 3);
    wait_result("d_zero", 3, 1'b0, W);
    @(posedge clk); #1;

    // Backpressure: 4*4+1 = 17 held while out_ready is low and in_valid high.
    bus.out_ready = 1'b0;
    send(4, 4, 1);
    bus.in_valid = 1'b1;
    bus.quotient = 8'd99;
    wait_result("bp", 17, 1'b1, W);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid",   bus.out_valid, 1);
      check("bp_hold_product", bus.product,   17);
      check("bp_hold_ready",   bus.in_ready,  0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_delivered_valid", bus.out_valid, 0);
    check("bp_delivered_ready", bus.in_ready,  1);

    // Reset three cycles into an operation.
    send(200, 100, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_product",   bus.product,   0);
    @(posedge clk);
    #1 reset = 1'b0;
    rst_e = cyc;
    send(2, 3, 1);
    check("post_rst_accept_edge", acc_e - rst_e, 1);
    wait_result("post_rst", 7, 1'b1, W);
    @(posedge clk); #1;

    // Random back-to-back with out_ready held high.
    bus.out_ready = 1'b1;
    prev_e = 0;
    for (int i = 0; i < 1000; i++) begin
      q = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 255));
      if (i % 50 == 1) d = 0;
      if (i % 50 == 2) q = 255;
      send(q, d, r);
      if (i > 0) check("b2b_spacing", acc_e - prev_e, W + 2);
      prev_e = acc_e;
    end

    n = 0;
    while (pend && n < 100) begin
      n++;
      @(posedge clk);
    end
    check("drain_done", pend, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
